// File: rtl/flex_down_timer.sv
`default_nettype none
// ============================================================================
// Module   : flex_down_timer
// Brief    : Loadable down-counting timer with a one-cycle expire pulse,
//            one-shot or auto-reload behaviour at terminal count.
// Revision : 1.0 - initial release
// ============================================================================
module flex_down_timer #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    start,
    input  logic [NUM_CNT_BITS-1:0] start_val,
    input  logic                    count_enable,
    input  logic                    auto_reload,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    expire_flag,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

    localparam logic [NUM_CNT_BITS-1:0] C_ONE  = NUM_CNT_BITS'(1);
    localparam logic [NUM_CNT_BITS-1:0] C_ZERO = '0;

    state_t                  state_q,  state_d;
    logic [NUM_CNT_BITS-1:0] count_q,  count_d;
    logic [NUM_CNT_BITS-1:0] period_q, period_d;
    logic                    expire_q, expire_d;
    logic                    busy_q,   busy_d;
    logic                    done_q,   done_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            count_q  <= C_ZERO;
            period_q <= C_ZERO;
            expire_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            expire_q <= expire_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Priority: clear, then start, then normal counting in the current state.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        period_d = period_q;
        expire_d = 1'b0;

        if (clear) begin
            state_d = S_IDLE;
            count_d = C_ZERO;
        end else if (start) begin
            period_d = start_val;
            if (start_val != C_ZERO) begin
                state_d = S_RUN;
                count_d = start_val;
            end else begin
                state_d  = S_EXPIRED;
                count_d  = C_ZERO;
                expire_d = 1'b1;
            end
        end else begin
            case (state_q)
                S_RUN: begin
                    if (count_enable) begin
                        if (count_q == C_ONE) begin
                            expire_d = 1'b1;
                            if (auto_reload) begin
                                count_d = period_q;
                            end else begin
                                state_d = S_EXPIRED;
                                count_d = C_ZERO;
                            end
                        end else begin
                            count_d = count_q - C_ONE;
                        end
                    end
                end
                S_EXPIRED: begin
                    count_d = C_ZERO;
                end
                default: begin
                    state_d = S_IDLE;
                    count_d = C_ZERO;
                end
            endcase
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_EXPIRED);
    end

    assign count_out   = count_q;
    assign expire_flag = expire_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
`default_nettype wire
